// File: rtl/fifo_arb_pkg.sv
// Shared types and constants for the packet-level FIFO write arbiter.
package fifo_arb_pkg;

    // Arbiter FSM: IDLE arbitrates, LOCKED forwards one packet
    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

    // Width of the per-packet accepted-beat counter
    localparam int PKT_BEATS_W = 16;

    // Increment that sticks at all-ones instead of wrapping
    function automatic logic [PKT_BEATS_W-1:0] sat_inc(input logic [PKT_BEATS_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_picker.sv
// Combinational round-robin picker: returns the first requesting port found
// scanning upward from the port after last_grant, wrapping at NUM_PORTS.
module rr_picker #(
    parameter int   NUM_PORTS = 4,
    localparam int  ID_WIDTH  = $clog2(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [ID_WIDTH-1:0]  last_grant,
    output logic [ID_WIDTH-1:0]  pick,
    output logic                 any
);

    // One extra bit so last_grant + offset cannot overflow before the wrap
    localparam int             SW = ID_WIDTH + 1;
    localparam logic [SW-1:0]  NP = SW'(NUM_PORTS);

    logic [SW-1:0]       cand_sum [NUM_PORTS];
    logic [ID_WIDTH-1:0] cand_idx [NUM_PORTS];

    // Candidate port at scan position gi (gi = 0 is the highest priority)
    generate
        for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_cand
            assign cand_sum[gi] = {1'b0, last_grant} + SW'(gi + 1);
            assign cand_idx[gi] = (cand_sum[gi] >= NP) ? ID_WIDTH'(cand_sum[gi] - NP)
                                                       : cand_sum[gi][ID_WIDTH-1:0];
        end
    endgenerate

    // Scan from lowest to highest priority so the highest-priority hit wins
    always_comb begin
        pick = '0;
        any  = 1'b0;
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            if (req[cand_idx[k]]) begin
                pick = cand_idx[k];
                any  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Packet-level round-robin arbiter sharing one FIFO write port among
// NUM_PORTS valid/ready requesters. A grant is held for a whole packet
// (until the beat carrying last is written); writes are throttled by full.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int  NUM_PORTS  = 4,
    parameter int  DATA_WIDTH = 32,
    localparam int ID_WIDTH   = $clog2(NUM_PORTS)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_PORTS-1:0]            in_valid,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] in_data,
    input  logic [NUM_PORTS-1:0]            in_last,
    output logic [NUM_PORTS-1:0]            in_ready,
    output logic [DATA_WIDTH-1:0]           fifo_din,
    output logic                            fifo_wr_en,
    input  logic                            fifo_full,
    output logic [ID_WIDTH-1:0]             grant_id,
    output logic                            busy
);

    arb_state_e               state_reg;
    arb_state_e               state_next;
    logic [ID_WIDTH-1:0]      grant_reg;
    logic [ID_WIDTH-1:0]      last_grant_reg;
    logic [PKT_BEATS_W-1:0]   pkt_beats_reg;

    logic [DATA_WIDTH-1:0]    data_arr [NUM_PORTS];
    logic [ID_WIDTH-1:0]      pick;
    logic                     any_req;
    logic                     locked;
    logic                     sel_valid;
    logic                     sel_last;
    logic                     accept;

    // Unpack the flat data bus into one word per port
    generate
        for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_unpack
            assign data_arr[gi] = in_data[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    rr_picker #(
        .NUM_PORTS (NUM_PORTS)
    ) u_picker (
        .req        (in_valid),
        .last_grant (last_grant_reg),
        .pick       (pick),
        .any        (any_req)
    );

    // A beat moves only from the locked port, and only when the FIFO has room
    assign locked    = (state_reg == LOCKED);
    assign sel_valid = in_valid[grant_reg];
    assign sel_last  = in_last[grant_reg];
    assign accept    = locked & sel_valid & ~fifo_full;

    // FSM state register; reset overrides every transition
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next state: lock on any request, release after the last beat is written
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (any_req) begin
                    state_next = LOCKED;
                end
            end
            LOCKED: begin
                if (accept && sel_last) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // FSM outputs: write strobe, data mux (zero when idle), busy flag
    always_comb begin
        fifo_wr_en = accept;
        fifo_din   = locked ? data_arr[grant_reg] : '0;
        busy       = locked;
    end

    // Ready goes only to the locked port and drops immediately when full
    generate
        for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_ready
            assign in_ready[gi] = locked && (grant_reg == ID_WIDTH'(gi)) && !fifo_full;
        end
    endgenerate

    assign grant_id = grant_reg;

    // Grant and round-robin pointer update on the arbitration cycle only
    always_ff @(posedge clk) begin
        if (rst) begin
            grant_reg      <= '0;
            last_grant_reg <= ID_WIDTH'(NUM_PORTS - 1);
        end else if (state_reg == IDLE && any_req) begin
            grant_reg      <= pick;
            last_grant_reg <= pick;
        end
    end

    // Accepted-beat counter for the current packet, cleared at each new grant
    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_beats_reg <= '0;
        end else if (state_reg == IDLE && any_req) begin
            pkt_beats_reg <= '0;
        end else if (accept) begin
            pkt_beats_reg <= sat_inc(pkt_beats_reg);
        end
    end

    // At most one port may see ready at a time
    a_ready_onehot: assert property (@(posedge clk) disable iff (rst)
        $onehot0(in_ready));

    // The FIFO must never see a write strobe while it reports full
    a_no_wr_when_full: assert property (@(posedge clk) disable iff (rst)
        !(fifo_wr_en && fifo_full));

    // The grant cannot move until the packet's last beat has been written
    a_grant_stable: assert property (@(posedge clk) disable iff (rst)
        (!rst && locked && !(accept && sel_last)) |=> (locked && $stable(grant_reg)));

    // Any accepted beat leaves a non-zero beat count behind
    a_beats_count: assert property (@(posedge clk) disable iff (rst)
        (!rst && accept) |=> (pkt_beats_reg != '0));

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed vector bench for fifo_wr_arbiter (4 ports, 32-bit data).
module tb_fifo_wr_arbiter;

    logic         clk;
    logic         rst;
    logic [3:0]   in_valid;
    logic [127:0] in_data;
    logic [3:0]   in_last;
    logic [3:0]   in_ready;
    logic [31:0]  fifo_din;
    logic         fifo_wr_en;
    logic         fifo_full;
    logic [1:0]   grant_id;
    logic         busy;

    int total = 0;
    int bad   = 0;

    fifo_wr_arbiter #(
        .NUM_PORTS  (4),
        .DATA_WIDTH (32)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_last    (in_last),
        .in_ready   (in_ready),
        .fifo_din   (fifo_din),
        .fifo_wr_en (fifo_wr_en),
        .fifo_full  (fifo_full),
        .grant_id   (grant_id),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One cycle of stimulus plus the outputs expected during that cycle
    typedef struct packed {
        logic       rst;
        logic [3:0] valid;
        logic [3:0] last;
        logic       full;
        logic [7:0] tag;
        logic [3:0] rdy;
        logic       wr;
        logic       busy;
        logic [1:0] gid;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic [3:0] va, input logic [3:0] la,
                                input logic f, input logic [7:0] t, input logic [3:0] er,
                                input logic ew, input logic eb, input logic [1:0] eg);
        vec_t v;
        v.rst = r; v.valid = va; v.last = la; v.full = f; v.tag = t;
        v.rdy = er; v.wr = ew; v.busy = eb; v.gid = eg;
        return v;
    endfunction

    task automatic chk(input string nm, input int idx, input string field,
                       input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s[%0d] %s got=%h want=%h", nm, idx, field, got, want);
        end
    endtask

    // Drive one vector at the falling edge and check outputs before the rising edge
    task automatic step(input vec_t v, input string nm, input int idx);
        logic [31:0] exp_din;
        @(negedge clk);
        rst       = v.rst;
        in_valid  = v.valid;
        in_last   = v.last;
        fifo_full = v.full;
        for (int p = 0; p < 4; p++) begin
            in_data[p*32 +: 32] = {8'(p), 16'h0000, v.tag};
        end
        exp_din = v.busy ? {6'h00, v.gid, 16'h0000, v.tag} : 32'h0;
        #1;
        $display("%s[%0d] rst=%b valid=%b last=%b full=%b -> ready=%b wr=%b busy=%b gid=%0d din=%h",
                 nm, idx, v.rst, v.valid, v.last, v.full, in_ready, fifo_wr_en, busy, grant_id, fifo_din);
        chk(nm, idx, "in_ready",   32'(in_ready),   32'(v.rdy));
        chk(nm, idx, "fifo_wr_en", 32'(fifo_wr_en), 32'(v.wr));
        chk(nm, idx, "busy",       32'(busy),       32'(v.busy));
        chk(nm, idx, "fifo_din",   fifo_din,        exp_din);
        if (v.busy) begin
            chk(nm, idx, "grant_id", 32'(grant_id), 32'(v.gid));
        end
    endtask

    vec_t tbl [30];

    initial begin
        // Reset state, single requester, wrap-around priority, then round robin
        tbl[0]  = mk(0, 4'b0000, 4'b0000, 0, 8'h00, 4'b0000, 0, 0, 0);
        tbl[1]  = mk(0, 4'b0100, 4'b0000, 0, 8'hA1, 4'b0000, 0, 0, 0);
        tbl[2]  = mk(0, 4'b0100, 4'b0000, 0, 8'hA1, 4'b0100, 1, 1, 2);
        tbl[3]  = mk(0, 4'b0100, 4'b0000, 0, 8'hA2, 4'b0100, 1, 1, 2);
        tbl[4]  = mk(0, 4'b0100, 4'b0100, 0, 8'hA3, 4'b0100, 1, 1, 2);
        tbl[5]  = mk(0, 4'b0000, 4'b0000, 0, 8'h00, 4'b0000, 0, 0, 0);
        tbl[6]  = mk(0, 4'b1000, 4'b0000, 0, 8'hB0, 4'b0000, 0, 0, 0);
        tbl[7]  = mk(0, 4'b1000, 4'b1000, 0, 8'hB0, 4'b1000, 1, 1, 3);
        tbl[8]  = mk(0, 4'b1001, 4'b0000, 0, 8'hC0, 4'b0000, 0, 0, 0);
        tbl[9]  = mk(0, 4'b1001, 4'b1001, 0, 8'hC0, 4'b0001, 1, 1, 0);
        tbl[10] = mk(0, 4'b1001, 4'b0000, 0, 8'hC1, 4'b0000, 0, 0, 0);
        tbl[11] = mk(0, 4'b1001, 4'b1001, 0, 8'hC1, 4'b1000, 1, 1, 3);
        tbl[12] = mk(0, 4'b0000, 4'b0000, 0, 8'h00, 4'b0000, 0, 0, 0);
        tbl[13] = mk(1, 4'b0000, 4'b0000, 0, 8'h00, 4'b0000, 0, 0, 0);
        tbl[14] = mk(0, 4'b1111, 4'b0000, 0, 8'hD0, 4'b0000, 0, 0, 0);
        tbl[15] = mk(0, 4'b1111, 4'b0000, 0, 8'hD1, 4'b0001, 1, 1, 0);
        tbl[16] = mk(0, 4'b1111, 4'b1111, 0, 8'hD2, 4'b0001, 1, 1, 0);
        tbl[17] = mk(0, 4'b1111, 4'b0000, 0, 8'hD3, 4'b0000, 0, 0, 0);
        tbl[18] = mk(0, 4'b1111, 4'b0000, 0, 8'hD4, 4'b0010, 1, 1, 1);
        tbl[19] = mk(0, 4'b1111, 4'b1111, 0, 8'hD5, 4'b0010, 1, 1, 1);
        tbl[20] = mk(0, 4'b1111, 4'b0000, 0, 8'hD6, 4'b0000, 0, 0, 0);
        tbl[21] = mk(0, 4'b1111, 4'b0000, 0, 8'hD7, 4'b0100, 1, 1, 2);
        tbl[22] = mk(0, 4'b1111, 4'b1111, 0, 8'hD8, 4'b0100, 1, 1, 2);
        tbl[23] = mk(0, 4'b1111, 4'b0000, 0, 8'hD9, 4'b0000, 0, 0, 0);
        tbl[24] = mk(0, 4'b1111, 4'b0000, 0, 8'hDA, 4'b1000, 1, 1, 3);
        tbl[25] = mk(0, 4'b1111, 4'b1111, 0, 8'hDB, 4'b1000, 1, 1, 3);
        tbl[26] = mk(0, 4'b1111, 4'b0000, 0, 8'hDC, 4'b0000, 0, 0, 0);
        tbl[27] = mk(0, 4'b1111, 4'b0000, 0, 8'hDD, 4'b0001, 1, 1, 0);
        tbl[28] = mk(0, 4'b1111, 4'b1111, 0, 8'hDE, 4'b0001, 1, 1, 0);
        tbl[29] = mk(0, 4'b0000, 4'b0000, 0, 8'h00, 4'b0000, 0, 0, 0);

        rst       = 1'b1;
        in_valid  = '0;
        in_last   = '0;
        in_data   = '0;
        fifo_full = 1'b0;
        repeat (3) @(posedge clk);

        for (int i = 0; i < 30; i++) begin
            step(tbl[i], "tbl", i);
        end

        // Port 1, 4-beat packet, FIFO full for 5 cycles after beat 2,
        // then full again on the last-beat cycle; port 0 waits throughout
        step(mk(0, 4'b0010, 4'b0000, 0, 8'hE1, 4'b0000, 0, 0, 0), "stall", 0);
        step(mk(0, 4'b0010, 4'b0000, 0, 8'hE1, 4'b0010, 1, 1, 1), "stall", 1);
        step(mk(0, 4'b0011, 4'b0000, 0, 8'hE2, 4'b0010, 1, 1, 1), "stall", 2);
        for (int i = 0; i < 5; i++) begin
            step(mk(0, 4'b0011, 4'b0000, 1, 8'hE3, 4'b0000, 0, 1, 1), "stall_full", i);
        end
        step(mk(0, 4'b0011, 4'b0000, 0, 8'hE3, 4'b0010, 1, 1, 1), "stall", 3);
        step(mk(0, 4'b0011, 4'b0010, 1, 8'hE4, 4'b0000, 0, 1, 1), "stall_last_full", 0);
        step(mk(0, 4'b0011, 4'b0010, 0, 8'hE4, 4'b0010, 1, 1, 1), "stall", 4);
        step(mk(0, 4'b0001, 4'b0000, 0, 8'hE5, 4'b0000, 0, 0, 0), "stall", 5);
        step(mk(0, 4'b0001, 4'b0001, 0, 8'hE5, 4'b0001, 1, 1, 0), "stall", 6);

        // Reset during beat 2 of a port-2 packet; next grant goes to lowest valid port
        step(mk(0, 4'b0100, 4'b0000, 0, 8'hF1, 4'b0000, 0, 0, 0), "rst_mid", 0);
        step(mk(0, 4'b0100, 4'b0000, 0, 8'hF1, 4'b0100, 1, 1, 2), "rst_mid", 1);
        step(mk(1, 4'b0100, 4'b0000, 0, 8'hF2, 4'b0100, 1, 1, 2), "rst_mid", 2);
        step(mk(0, 4'b1010, 4'b0010, 0, 8'hF3, 4'b0000, 0, 0, 0), "rst_mid", 3);
        step(mk(0, 4'b1010, 4'b0010, 0, 8'hF3, 4'b0010, 1, 1, 1), "rst_mid", 4);
        step(mk(0, 4'b1000, 4'b1000, 0, 8'hF4, 4'b0000, 0, 0, 0), "rst_mid", 5);
        step(mk(0, 4'b1000, 4'b1000, 0, 8'hF4, 4'b1000, 1, 1, 3), "rst_mid", 6);
        step(mk(0, 4'b0000, 4'b0000, 0, 8'h00, 4'b0000, 0, 0, 0), "rst_mid", 7);

        // Port 2 drops valid for 3 cycles mid-packet while port 0 requests
        step(mk(0, 4'b0100, 4'b0000, 0, 8'h71, 4'b0000, 0, 0, 0), "drop", 0);
        step(mk(0, 4'b0101, 4'b0000, 0, 8'h71, 4'b0100, 1, 1, 2), "drop", 1);
        for (int i = 0; i < 3; i++) begin
            step(mk(0, 4'b0001, 4'b0000, 0, 8'h72, 4'b0100, 0, 1, 2), "drop_gap", i);
        end
        step(mk(0, 4'b0101, 4'b0000, 0, 8'h72, 4'b0100, 1, 1, 2), "drop", 2);
        step(mk(0, 4'b0101, 4'b0000, 0, 8'h73, 4'b0100, 1, 1, 2), "drop", 3);
        step(mk(0, 4'b0101, 4'b0101, 0, 8'h74, 4'b0100, 1, 1, 2), "drop", 4);
        step(mk(0, 4'b0001, 4'b0000, 0, 8'h75, 4'b0000, 0, 0, 0), "drop", 5);
        step(mk(0, 4'b0001, 4'b0001, 0, 8'h75, 4'b0001, 1, 1, 0), "drop", 6);
        step(mk(0, 4'b0000, 4'b0000, 0, 8'h00, 4'b0000, 0, 0, 0), "drop", 7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
